// File: rtl/sd_cmd_sched.sv
// sd_cmd_sched: arbitrates the single SD CMD issue path between host Command register
// writes and data-path Auto CMD12 requests. Auto CMD12 support: `define SDHCI_AUTO_CMD12_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no command in flight; latch auto (priority) or host command
// ISSUE     | cmd_valid_o high, waiting for serializer ready
// WAIT_CMD  | command shifting out, waiting for cmd_done_i
// WAIT_RSP  | waiting for rsp_done_i or the response timeout
// DONE      | one cycle; completion pulses are visible, inhibits resolved

module sd_cmd_sched #(
  parameter int unsigned RspTimeoutCycles = 64*1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        host_cmd_valid_i,
  input  logic [5:0]  host_cmd_index_i,
  input  logic [31:0] host_cmd_arg_i,
  input  logic [1:0]  host_rsp_type_i,
  input  logic        host_data_present_i,
  input  logic        auto_cmd12_req_i,
  input  logic        dat_active_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic [1:0]  cmd_rsp_type_o,
  input  logic        cmd_done_i,
  input  logic        rsp_done_i,
  input  logic        rsp_err_i,
  output logic        cmd_inhibit_o,
  output logic        dat_inhibit_o,
  output logic        cmd_complete_o,
  output logic        rsp_timeout_o,
  output logic        host_cmd_dropped_o,
  output logic        auto_cmd12_done_o,
  output logic        auto_cmd12_err_o
);

  localparam int unsigned CntW = (RspTimeoutCycles > 1) ? $clog2(RspTimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RspTimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_CMD,
    ST_WAIT_RSP,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     arg_q, arg_d;
  logic [1:0]      type_q, type_d;
  logic            data_q, data_d;
  logic            err_q, err_d;
  logic            dat_active_q;

  logic cmd_valid_q, cmd_valid_d;
  logic cmd_inh_q, cmd_inh_d;
  logic dat_inh_q, dat_inh_d;
  logic complete_q, complete_d;
  logic timeout_q, timeout_d;
  logic dropped_q, dropped_d;

  logic fin, fin_err, fin_tmo;
  logic host_blocked;
  logic [CntW-1:0] cnt_inc;

`ifdef SDHCI_AUTO_CMD12_EN
  logic auto_pend_q, auto_pend_d;
  logic is_auto_q, is_auto_d;
  logic a_done_q, a_done_d;
  logic a_err_q, a_err_d;
  logic auto_go, auto_latch;

  assign auto_go      = auto_pend_q | auto_cmd12_req_i;
  assign host_blocked = (state_q != ST_IDLE) | auto_go;
`else
  logic unused_auto_req;

  assign unused_auto_req = auto_cmd12_req_i;
  assign host_blocked    = (state_q != ST_IDLE);
`endif

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    type_d     = type_q;
    data_d     = data_q;
    err_d      = err_q;
    dat_inh_d  = dat_inh_q;
    complete_d = 1'b0;
    timeout_d  = 1'b0;
    dropped_d  = host_cmd_valid_i & host_blocked;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_tmo    = 1'b0;
`ifdef SDHCI_AUTO_CMD12_EN
    is_auto_d  = is_auto_q;
    a_done_d   = 1'b0;
    a_err_d    = 1'b0;
    auto_latch = 1'b0;
`endif

    // Falling edge of transfer activity releases DAT; a new latch below overrides it.
    if (dat_active_q && !dat_active_i) dat_inh_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
`ifdef SDHCI_AUTO_CMD12_EN
        if (auto_go) begin
          idx_d      = 6'd12;
          arg_d      = '0;
          type_d     = 2'b11;
          data_d     = 1'b0;
          err_d      = 1'b0;
          is_auto_d  = 1'b1;
          auto_latch = 1'b1;
          state_d    = ST_ISSUE;
        end else
`endif
        if (host_cmd_valid_i) begin
          idx_d   = host_cmd_index_i;
          arg_d   = host_cmd_arg_i;
          type_d  = host_rsp_type_i;
          data_d  = host_data_present_i;
          err_d   = 1'b0;
`ifdef SDHCI_AUTO_CMD12_EN
          is_auto_d = 1'b0;
`endif
          state_d = ST_ISSUE;
          if (host_data_present_i || host_rsp_type_i == 2'b11) dat_inh_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready_i) begin
          state_d = ST_WAIT_CMD;
          cnt_d   = '0;
        end
      end
      ST_WAIT_CMD: begin
        cnt_d = cnt_inc;
        if (cmd_done_i) begin
          if (type_q == 2'b00) begin
            state_d = ST_DONE;
            fin     = 1'b1;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        cnt_d = cnt_inc;
        if (rsp_done_i) begin
          state_d = ST_DONE;
          fin     = 1'b1;
          fin_err = rsp_err_i;
        end else if (cnt_q == CntLast) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_tmo   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (err_q || (type_q == 2'b11 && !data_q)) dat_inh_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      err_d = fin_err;
`ifdef SDHCI_AUTO_CMD12_EN
      if (is_auto_q) begin
        a_done_d = 1'b1;
        a_err_d  = fin_err;
      end else begin
        complete_d = ~fin_tmo;
      end
`else
      complete_d = ~fin_tmo;
`endif
    end

    cmd_valid_d = (state_d == ST_ISSUE);
`ifdef SDHCI_AUTO_CMD12_EN
    auto_pend_d = auto_go & ~auto_latch;
    cmd_inh_d   = (state_d != ST_IDLE) | auto_pend_d;
`else
    cmd_inh_d   = (state_d != ST_IDLE);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      arg_q        <= '0;
      type_q       <= '0;
      data_q       <= 1'b0;
      err_q        <= 1'b0;
      dat_active_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_inh_q    <= 1'b0;
      dat_inh_q    <= 1'b0;
      complete_q   <= 1'b0;
      timeout_q    <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      arg_q        <= arg_d;
      type_q       <= type_d;
      data_q       <= data_d;
      err_q        <= err_d;
      dat_active_q <= dat_active_i;
      cmd_valid_q  <= cmd_valid_d;
      cmd_inh_q    <= cmd_inh_d;
      dat_inh_q    <= dat_inh_d;
      complete_q   <= complete_d;
      timeout_q    <= timeout_d;
      dropped_q    <= dropped_d;
    end
  end

`ifdef SDHCI_AUTO_CMD12_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      auto_pend_q <= 1'b0;
      is_auto_q   <= 1'b0;
      a_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
    end else begin
      auto_pend_q <= auto_pend_d;
      is_auto_q   <= is_auto_d;
      a_done_q    <= a_done_d;
      a_err_q     <= a_err_d;
    end
  end

  assign auto_cmd12_done_o = a_done_q;
  assign auto_cmd12_err_o  = a_err_q;
`else
  assign auto_cmd12_done_o = 1'b0;
  assign auto_cmd12_err_o  = 1'b0;
`endif

  assign cmd_valid_o        = cmd_valid_q;
  assign cmd_index_o        = idx_q;
  assign cmd_arg_o          = arg_q;
  assign cmd_rsp_type_o     = type_q;
  assign cmd_inhibit_o      = cmd_inh_q;
  assign dat_inhibit_o      = dat_inh_q;
  assign cmd_complete_o     = complete_q;
  assign rsp_timeout_o      = timeout_q;
  assign host_cmd_dropped_o = dropped_q;

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Directed bench for sd_cmd_sched with a 16-cycle response timeout; the Auto CMD12
// steps build only when SDHCI_AUTO_CMD12_EN is defined.

module tb_sd_cmd_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        host_cmd_valid_i;
  logic [5:0]  host_cmd_index_i;
  logic [31:0] host_cmd_arg_i;
  logic [1:0]  host_rsp_type_i;
  logic        host_data_present_i;
  logic        auto_cmd12_req_i;
  logic        dat_active_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [1:0]  cmd_rsp_type_o;
  logic        cmd_done_i;
  logic        rsp_done_i;
  logic        rsp_err_i;
  logic        cmd_inhibit_o;
  logic        dat_inhibit_o;
  logic        cmd_complete_o;
  logic        rsp_timeout_o;
  logic        host_cmd_dropped_o;
  logic        auto_cmd12_done_o;
  logic        auto_cmd12_err_o;

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clk_i = ~clk_i;

  sd_cmd_sched #(.RspTimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_cmd_valid_i(host_cmd_valid_i), .host_cmd_index_i(host_cmd_index_i),
    .host_cmd_arg_i(host_cmd_arg_i), .host_rsp_type_i(host_rsp_type_i),
    .host_data_present_i(host_data_present_i), .auto_cmd12_req_i(auto_cmd12_req_i),
    .dat_active_i(dat_active_i), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o), .cmd_rsp_type_o(cmd_rsp_type_o),
    .cmd_done_i(cmd_done_i), .rsp_done_i(rsp_done_i), .rsp_err_i(rsp_err_i),
    .cmd_inhibit_o(cmd_inhibit_o), .dat_inhibit_o(dat_inhibit_o),
    .cmd_complete_o(cmd_complete_o), .rsp_timeout_o(rsp_timeout_o),
    .host_cmd_dropped_o(host_cmd_dropped_o), .auto_cmd12_done_o(auto_cmd12_done_o),
    .auto_cmd12_err_o(auto_cmd12_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host(input logic [5:0] idx, input logic [31:0] arg,
                      input logic [1:0] typ, input logic dp);
    host_cmd_index_i    = idx;
    host_cmd_arg_i      = arg;
    host_rsp_type_i     = typ;
    host_data_present_i = dp;
    host_cmd_valid_i    = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    host_cmd_valid_i = 0; host_cmd_index_i = 0; host_cmd_arg_i = 0;
    host_rsp_type_i = 0; host_data_present_i = 0; auto_cmd12_req_i = 0;
    dat_active_i = 0; cmd_ready_i = 0; cmd_done_i = 0; rsp_done_i = 0; rsp_err_i = 0;
    #12;
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_inh", {cmd_inhibit_o, dat_inhibit_o}, 0);
    chk("rst_pulses", {cmd_complete_o, rsp_timeout_o, host_cmd_dropped_o,
                       auto_cmd12_done_o, auto_cmd12_err_o}, 0);
    chk("rst_fields", {cmd_index_o, cmd_arg_o, cmd_rsp_type_o}, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // CMD17, type 10, data present, ready at once
    host(6'd17, 32'h0000_0200, 2'b10, 1'b1);
    tick();
    host_cmd_valid_i = 0;
    chk("c17_valid", cmd_valid_o, 1);
    chk("c17_inh", {cmd_inhibit_o, dat_inhibit_o}, 2'b11);
    chk("c17_fields", {cmd_index_o, cmd_rsp_type_o}, {6'd17, 2'b10});
    chk("c17_arg", cmd_arg_o, 32'h200);
    cmd_ready_i = 1;
    tick();
    cmd_ready_i = 0;
    dat_active_i = 1;
    chk("c17_valid_drop", cmd_valid_o, 0);
    tick(); tick(); tick();
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    chk("c17_no_early_cmpl", cmd_complete_o, 0);
    host(6'd5, 32'h1, 2'b00, 1'b0);
    tick();
    host_cmd_valid_i = 0;
    chk("c17_dropped", host_cmd_dropped_o, 1);
    chk("c17_field_hold", cmd_index_o, 17);
    tick();
    chk("c17_dropped_once", host_cmd_dropped_o, 0);
    tick(); tick();
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk("c17_complete", {cmd_complete_o, cmd_inhibit_o, dat_inhibit_o}, 3'b111);
    tick();
    chk("c17_after", {cmd_complete_o, cmd_inhibit_o, dat_inhibit_o}, 3'b001);
    tick();
    chk("c17_dat_hold", dat_inhibit_o, 1);
    dat_active_i = 0;
    tick();
    chk("c17_dat_fall", dat_inhibit_o, 0);

    // CMD0, type 00, ready delayed, stray rsp_done ignored
    host(6'd0, 32'h0, 2'b00, 1'b0);
    tick();
    host_cmd_valid_i = 0;
    chk("c0_valid", {cmd_valid_o, cmd_inhibit_o, dat_inhibit_o}, 3'b110);
    tick(); tick();
    chk("c0_valid_hold", cmd_valid_o, 1);
    cmd_ready_i = 1;
    tick();
    cmd_ready_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    chk("c0_complete", {cmd_complete_o, dat_inhibit_o}, 2'b10);
    tick();
    chk("c0_idle", {cmd_complete_o, cmd_inhibit_o, dat_inhibit_o}, 0);
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk("stray_rsp", {cmd_complete_o, cmd_inhibit_o, cmd_valid_o}, 0);

    // Type 11, no data: no response -> timeout 16 cycles after acceptance
    host(6'd7, 32'h1234, 2'b11, 1'b0);
    tick();
    host_cmd_valid_i = 0;
    chk("tmo_dat_set", dat_inhibit_o, 1);
    cmd_ready_i = 1;
    tick();
    cmd_ready_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      seen |= rsp_timeout_o;
    end
    chk("tmo_not_early", seen, 0);
    tick();
    chk("tmo_pulse", {rsp_timeout_o, cmd_complete_o, cmd_inhibit_o}, 3'b101);
    tick();
    chk("tmo_cleared", {rsp_timeout_o, cmd_inhibit_o, dat_inhibit_o}, 0);

    // Type 10 with data and a response error: completes, DAT released in DONE
    host(6'd18, 32'h40, 2'b10, 1'b1);
    cmd_ready_i = 1;
    tick();
    host_cmd_valid_i = 0;
    tick();
    cmd_ready_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    rsp_done_i = 1; rsp_err_i = 1;
    tick();
    rsp_done_i = 0; rsp_err_i = 0;
    chk("err_complete", {cmd_complete_o, dat_inhibit_o}, 2'b11);
    tick();
    chk("err_dat_clr", {cmd_inhibit_o, dat_inhibit_o}, 0);

    // Reset during WAIT_RSP, then a fresh command
    host(6'd8, 32'h1AA, 2'b10, 1'b1);
    cmd_ready_i = 1;
    tick();
    host_cmd_valid_i = 0;
    tick();
    cmd_ready_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_out", {cmd_valid_o, cmd_inhibit_o, dat_inhibit_o, cmd_complete_o}, 0);
    chk("rst_mid_fields", {cmd_index_o, cmd_arg_o}, 0);
    tick();
    rst_ni = 1'b1;
    host(6'd55, 32'h0, 2'b10, 1'b0);
    tick();
    host_cmd_valid_i = 0;
    chk("post_rst_accept", {cmd_valid_o, cmd_index_o}, {1'b1, 6'd55});
    cmd_ready_i = 1;
    tick();
    cmd_ready_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk("post_rst_cmpl", cmd_complete_o, 1);
    tick();

`ifdef SDHCI_AUTO_CMD12_EN
    // Two auto requests during a busy host command merge into one CMD12
    host(6'd25, 32'h800, 2'b11, 1'b1);
    cmd_ready_i = 1;
    tick();
    host_cmd_valid_i = 0;
    tick();
    cmd_ready_i = 0;
    auto_cmd12_req_i = 1;
    tick();
    auto_cmd12_req_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    auto_cmd12_req_i = 1;
    tick();
    auto_cmd12_req_i = 0;
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk("a12_host_cmpl", {cmd_complete_o, auto_cmd12_done_o}, 2'b10);
    tick();
    chk("a12_gap_inh", {cmd_valid_o, cmd_inhibit_o}, 2'b01);
    tick();
    chk("a12_issue", {cmd_valid_o, cmd_index_o, cmd_rsp_type_o}, {1'b1, 6'd12, 2'b11});
    chk("a12_arg", cmd_arg_o, 0);
    cmd_ready_i = 1;
    tick();
    cmd_ready_i = 0;
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk("a12_done", {auto_cmd12_done_o, auto_cmd12_err_o, cmd_complete_o}, 3'b100);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= cmd_valid_o | auto_cmd12_done_o;
    end
    chk("a12_single", seen, 0);
    chk("a12_inh_clr", {cmd_inhibit_o, dat_inhibit_o}, 0);

    // Auto request and host strobe in the same IDLE cycle
    auto_cmd12_req_i = 1;
    host(6'd17, 32'h0, 2'b10, 1'b1);
    tick();
    auto_cmd12_req_i = 0;
    host_cmd_valid_i = 0;
    chk("prio_issue", {cmd_valid_o, cmd_index_o, host_cmd_dropped_o}, {1'b1, 6'd12, 1'b1});
    cmd_ready_i = 1;
    tick();
    cmd_ready_i = 0;
    chk("prio_drop_once", host_cmd_dropped_o, 0);
    cmd_done_i = 1;
    tick();
    cmd_done_i = 0;
    rsp_done_i = 1; rsp_err_i = 1;
    tick();
    rsp_done_i = 0; rsp_err_i = 0;
    chk("prio_a12_err", {auto_cmd12_done_o, auto_cmd12_err_o}, 2'b11);
    tick();
`else
    // Without Auto CMD12 support the request line has no effect
    auto_cmd12_req_i = 1;
    tick();
    auto_cmd12_req_i = 0;
    chk("noauto_idle", {cmd_valid_o, cmd_inhibit_o}, 0);
    tick();
    chk("noauto_out", {cmd_valid_o, auto_cmd12_done_o, auto_cmd12_err_o}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
